fredkin_seq_multiplier: RTL and testbench
=========================================

# fredkin_seq_multiplier

Sequential unsigned shift-add multiplier whose partial-product selection is built from `fredkin_gate` instances, one per multiplicand bit. It consumes the gates' controlled-swap outputs: with z tied low, output r equals x AND y. The block sits directly downstream of the Fredkin gate array and produces the scalar products consumed by the matrix-multiplier accumulation stage. It uses a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; must be 2 or more.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE or DONE.
- a  in  WIDTH  multiplicand, unsigned; captured on an accepted start.
- b  in  WIDTH  multiplier, unsigned; captured on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  high for exactly one cycle, in state DONE.
- product  out  2*WIDTH  result; valid from done and held until the next accepted start.

## Operation
- Reset is synchronous: on any edge with rst=1, the block enters IDLE and clears every register.
  - Reset values: busy=0, done=0, product=0, step counter=0, accumulator=0.
  - rst overrides start.
- Registers:
  - mcand, WIDTH bits.
  - acc, 2*WIDTH+1 bits: {carry, hi[WIDTH], lo[WIDTH]}.
  - cnt, ceil(log2(WIDTH+1)) bits.
- States:
  - IDLE: start=1 → latch mcand=a and acc={0, zeros, b}; set cnt=0; go to RUN.
  - RUN: one multiplier bit is processed per cycle.
    - Partial product pp[i] is the r output of fredkin_gate(x=acc[0], y=mcand[i], z=0).
    - {carry,hi} = hi + pp, a WIDTH+1-bit sum. Then shift the whole acc right by 1, with 0 entering the MSB.
    - cnt increments each step. After the step where cnt reaches WIDTH-1, go to DONE.
  - DONE: done=1 and product=acc[2*WIDTH-1:0].
    - start=1 → latch new operands and go to RUN, for back-to-back operation.
    - Otherwise go to IDLE.
- product is a separate register. It loads on entry to DONE and keeps its value through IDLE and through the following RUN.
- start is ignored in RUN. Operands a and b are don't-care except on an accepted start edge.
- Arithmetic: the result is exact unsigned, a*b < 2^(2*WIDTH), so no overflow is possible. The carry bit is consumed by the shift each step.
- Gate p outputs (pass-through of x) and q outputs are unused.

## Timing
- Start accepted at edge E0 (the state changes IDLE→RUN at E0).
- RUN occupies the WIDTH cycles following E0, with steps at edges E1..E_WIDTH.
- State DONE, done=1 and the new product are visible after edge E_WIDTH.
  - Latency from the start-accept edge to done is WIDTH cycles.
- busy=1 for exactly WIDTH cycles per operation.
- Throughput with start held high: one result every WIDTH+1 cycles.
- Reset mid-RUN:
  - The operation is abandoned and done is never pulsed for it.
  - product reads 0 on the cycle after the reset edge.
- busy and done are never high in the same cycle.

## Test plan
- WIDTH=8, a=13, b=11, single start pulse → busy high for 8 cycles; done high for 1 cycle at 8 cycles after the accept edge; product=143.
- a=255, b=255 → product=65025 (0xFE01); corners a=0,b=200 → 0; a=1,b=255 → 255.
- Pulse start with a=9,b=9 at RUN cycle 3 of a 7×6 operation → product=42, no extra done pulse, state goes to IDLE afterwards.
- Hold start high with operand pairs (3,5) then (100,2) → done pulses 9 cycles apart; products 15 then 200; product holds 15 through the second RUN.
- Assert rst during RUN cycle 4 of 200×200 → next cycle busy=0, done=0, product=0, state IDLE; a new start with 2×3 gives 6.
- Random regression, 1000 operand pairs against a reference multiply; also WIDTH=4 check 15×15=225.

Source files
------------

// File: rtl/fredkin_seq_multiplier.sv
// fredkin_seq_multiplier
// Sequential unsigned shift-add multiplier. One multiplier bit is retired per
// cycle; the partial product for that bit is formed by a row of Fredkin
// (controlled-swap) gates whose z input is tied low, so r = x AND y.
// Handshake: start is accepted in IDLE or DONE, busy marks RUN, done pulses
// for one cycle in DONE, and product holds until the next result lands.

// Controlled-swap primitive: x is the control line and passes straight
// through on p. When x=1 the y and z lines are exchanged onto q and r.
module fredkin_gate (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic p,
  output logic q,
  output logic r
);

  assign p = x;
  assign q = x ? z : y;
  assign r = x ? y : z;

endmodule

module fredkin_seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  // Accumulator layout is {carry, hi[WIDTH], lo[WIDTH]}; lo starts as the
  // multiplier and is shifted out one bit per step while the product grows
  // into hi and the vacated lo bits.
  localparam int ACC_W = 2*WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [WIDTH-1:0]     mcand_r;
  logic [WIDTH-1:0]     mcand_next_s;
  logic [ACC_W-1:0]     acc_r;
  logic [ACC_W-1:0]     acc_next_s;
  logic [ACC_W-1:0]     acc_step_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [CNT_W-1:0]     cnt_next_s;
  logic [2*WIDTH-1:0]   product_r;
  logic [2*WIDTH-1:0]   product_next_s;
  logic                 busy_r;
  logic                 done_r;

  logic [WIDTH-1:0]     pp_s;
  logic [WIDTH:0]       sum_s;

  // Gate outputs that the multiplier has no use for: p mirrors the control
  // bit and q carries the swapped-out zero. The stored carry is always zero
  // at the start of a step because the previous shift consumed it.
  logic [WIDTH-1:0]     unused_p_s;
  logic [WIDTH-1:0]     unused_q_s;
  logic                 unused_carry_s;

  assign unused_carry_s = acc_r[ACC_W-1];

  // One Fredkin gate per multiplicand bit, all controlled by the current
  // multiplier bit acc[0]; r yields mcand[i] when that bit is set, else 0.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      fredkin_gate u_gate (
        .x (acc_r[0]),
        .y (mcand_r[gi]),
        .z (1'b0),
        .p (unused_p_s[gi]),
        .q (unused_q_s[gi]),
        .r (pp_s[gi])
      );
    end
  endgenerate

  // Add the selected partial product into the high half, then shift the
  // whole accumulator right by one with zero entering the top.
  always_comb begin
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, pp_s};
    acc_step_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
  end

  // Next-state and next-register values for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_next_s   = state_r;
    mcand_next_s   = mcand_r;
    acc_next_s     = acc_r;
    cnt_next_s     = cnt_r;
    product_next_s = product_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_next_s = RUN;
          mcand_next_s = a;
          acc_next_s   = {1'b0, {WIDTH{1'b0}}, b};
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        acc_next_s = acc_step_s;
        cnt_next_s = cnt_r + CNT_ONE;
        if (cnt_r == LAST_CNT) begin
          state_next_s   = DONE;
          product_next_s = acc_step_s[2*WIDTH-1:0];
        end else begin
          state_next_s = RUN;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; rst clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      mcand_r   <= {WIDTH{1'b0}};
      acc_r     <= {ACC_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      product_r <= {(2*WIDTH){1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      mcand_r   <= mcand_next_s;
      acc_r     <= acc_next_s;
      cnt_r     <= cnt_next_s;
      product_r <= product_next_s;
      busy_r    <= (state_next_s == RUN);
      done_r    <= (state_next_s == DONE);
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_fredkin_seq_multiplier.sv
// Scoreboard bench for fredkin_seq_multiplier: stimulus pushes a*b into a
// queue, monitors pop and compare whenever done is presented. A second
// instance at WIDTH=4 covers the narrow configuration.
module tb_fredkin_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        rst4;
  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        busy4;
  logic        done4;
  logic [7:0]  product4;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  exp4_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  fredkin_seq_multiplier #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  fredkin_seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(product4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair for a single cycle and record the reference result.
  task automatic issue(input logic [7:0] x, input logic [7:0] y);
    int prod;
    prod = int'(x) * int'(y);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(prod[15:0]);
    tick();
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  // Bounded wait for done; an expired bound counts as a failed comparison.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  // Monitor for the WIDTH=8 instance.
  logic        rst_edge;
  logic [15:0] hold_exp = 16'd0;
  int          busy_len = 0;
  logic        prev_done = 1'b0;
  logic [15:0] popped;

  initial begin : monitor
    forever begin
      @(posedge clk);
      rst_edge = rst;
      @(negedge clk);
      if (rst_edge) begin
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        hold_exp  = 16'd0;
        busy_len  = 0;
        prev_done = 1'b0;
      end else begin
        check("busy_done_exclusive", 32'(busy && done), 32'd0);
        if (done) begin
          check("done_single_cycle", 32'(prev_done), 32'd0);
          check("busy_length", 32'(busy_len), 32'd8);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL unexpected_done: got done with product %0d, expected no done", product);
          end else begin
            popped = exp_q.pop_front();
            check("product", 32'(product), 32'(popped));
            hold_exp = popped;
          end
          busy_len = 0;
        end else begin
          check("product_hold", 32'(product), 32'(hold_exp));
          if (busy) busy_len++;
          else busy_len = 0;
        end
        prev_done = done;
      end
    end
  end

  // Monitor for the WIDTH=4 instance.
  initial begin : monitor4
    forever begin
      @(negedge clk);
      if (done4) begin
        if (exp4_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL w4_unexpected_done: got done with product %0d, expected no done", product4);
        end else begin
          check("w4_product", 32'(product4), 32'(exp4_q.pop_front()));
        end
      end
    end
  end

  initial begin : stimulus
    int t1;
    int t2;
    logic [7:0] x;
    logic [7:0] y;

    rst = 1'b1; start = 1'b0; a = 8'd0; b = 8'd0;
    rst4 = 1'b1; start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    rst4 = 1'b0;
    tick();

    // Basic single operation and corner operands.
    issue(8'd13, 8'd11);
    wait_done();
    tick();
    issue(8'd255, 8'd255); wait_done();
    issue(8'd0, 8'd200);   wait_done();
    issue(8'd1, 8'd255);   wait_done();
    tick();
    tick();

    // start pulsed mid-RUN must be ignored.
    start = 1'b1; a = 8'd7; b = 8'd6; exp_q.push_back(16'd42);
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'd9; b = 8'd9;
    tick();
    start = 1'b0;
    wait_done();
    tick();
    check("idle_after_done_busy", 32'(busy), 32'd0);
    check("idle_after_done_done", 32'(done), 32'd0);
    repeat (12) tick();

    // start held high: back-to-back operations.
    start = 1'b1; a = 8'd3; b = 8'd5; exp_q.push_back(16'd15);
    tick();
    a = 8'd100; b = 8'd2; exp_q.push_back(16'd200);
    wait_done();
    t1 = cyc;
    tick();
    start = 1'b0;
    wait_done();
    t2 = cyc;
    check("back_to_back_spacing", 32'(t2 - t1), 32'd9);
    tick();
    tick();

    // Reset in the middle of RUN abandons the operation.
    start = 1'b1; a = 8'd200; b = 8'd200; exp_q.push_back(16'd40000);
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    exp_q.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_product", 32'(product), 32'd0);
    repeat (12) tick();
    issue(8'd2, 8'd3);
    wait_done();
    tick();

    // Random regression against the plain-arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0:       x = 8'd0;
        1:       x = 8'd255;
        default: x = 8'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       y = 8'd0;
        1:       y = 8'd255;
        default: y = 8'($urandom);
      endcase
      issue(x, y);
      wait_done();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    tick();
    tick();

    // Narrow configuration.
    start4 = 1'b1; a4 = 4'd15; b4 = 4'd15; exp4_q.push_back(8'd225);
    tick();
    start4 = 1'b0;
    repeat (8) tick();
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd6; exp4_q.push_back(8'd54);
    tick();
    start4 = 1'b0;
    repeat (8) tick();

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("w4_scoreboard_drained", 32'(exp4_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
